// File: rtl/count_seq_pkg.sv
// count_sequencer shared types and helpers.
// State encoding, widths and expected-count arithmetic.
package count_seq_pkg;

    localparam int CNT_W   = 6;
    localparam int DIGIT_W = 3;
    localparam int TMR_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    // Count the counter should show after 'issued' increments from 'base'.
    // Wrap past 63 is normal counter behaviour, so the sum is modulo 64.
    function automatic logic [CNT_W-1:0] exp_count(
        input logic [CNT_W-1:0] base,
        input logic [CNT_W-1:0] issued
    );
        return base + issued;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter with a zero flag.
// One instance times the CLEAR, RUN and DRAIN phases.
module seq_timer
    import count_seq_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_next,
    output logic         o_zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load wins over decrement; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_next = cnt_d;
    assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven controller for the octal counter.
// Gates the counter enable for an exact run length and checks the count.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int SYNC_LAT = 2,
    parameter int CLR_LEN  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cmd_valid,
    output logic               o_cmd_ready,
    input  logic [CNT_W-1:0]   i_cmd_target,
    input  logic               i_cmd_clear,
    input  logic               i_abort,
    output logic               o_cnt_enable,
    output logic               o_cnt_rst_n,
    input  logic [DIGIT_W-1:0] i_count_low,
    input  logic [DIGIT_W-1:0] i_count_high,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic [CNT_W-1:0]   o_final_count
);

    localparam logic [TMR_W-1:0] CLR_VAL = TMR_W'(CLR_LEN + SYNC_LAT);
    localparam logic [TMR_W-1:0] DRN_VAL = TMR_W'(SYNC_LAT);
    localparam logic [TMR_W-1:0] RST_HI  = TMR_W'(SYNC_LAT);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] tgt_q, tgt_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic             abort_seen_q, abort_seen_d;

    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             en_q, en_d;
    logic             rst_n_q, rst_n_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] fin_q, fin_d;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_dec;
    logic [TMR_W-1:0] tmr_next;
    logic             tmr_zero;

    logic [CNT_W-1:0] cnt;
    logic             accept;

    assign cnt    = {i_count_high, i_count_low};
    assign accept = i_cmd_valid && ready_q;

    seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_dec      (tmr_dec),
        .o_next     (tmr_next),
        .o_zero     (tmr_zero)
    );

    // Next-state, command latching and phase timer control.
    always_comb begin
        state_d      = state_q;
        tgt_d        = tgt_q;
        base_d       = base_q;
        issued_d     = issued_q;
        abort_seen_d = abort_seen_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_dec      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    tgt_d        = i_cmd_target;
                    base_d       = i_cmd_clear ? '0 : cnt;
                    issued_d     = '0;
                    abort_seen_d = 1'b0;
                    tmr_load     = 1'b1;
                    if (i_cmd_clear) begin
                        state_d = ST_CLEAR;
                        tmr_val = CLR_VAL;
                    end else if (i_cmd_target != '0) begin
                        state_d = ST_RUN;
                        tmr_val = TMR_W'(i_cmd_target) - TMR_W'(1);
                    end else begin
                        state_d = ST_DRAIN;
                        tmr_val = DRN_VAL;
                    end
                end
            end
            ST_CLEAR: begin
                tmr_dec = 1'b1;
                if (i_abort) begin
                    abort_seen_d = 1'b1;
                end
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    if ((tgt_q != '0) && !(abort_seen_q || i_abort)) begin
                        state_d = ST_RUN;
                        tmr_val = TMR_W'(tgt_q) - TMR_W'(1);
                    end else begin
                        state_d = ST_DRAIN;
                        tmr_val = DRN_VAL;
                    end
                end
            end
            ST_RUN: begin
                tmr_dec  = 1'b1;
                issued_d = issued_q + CNT_W'(1);
                if (tmr_zero || i_abort) begin
                    state_d  = ST_DRAIN;
                    tmr_load = 1'b1;
                    tmr_val  = DRN_VAL;
                end
            end
            ST_DRAIN: begin
                tmr_dec = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs follow the state being entered so they line up with it.
    always_comb begin
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        en_d    = (state_d == ST_RUN);
        rst_n_d = !((state_d == ST_CLEAR) && (tmr_next > RST_HI));
        done_d  = (state_d == ST_DONE);
        err_d   = err_q;
        fin_d   = fin_q;
        if (accept) begin
            err_d = 1'b0;
            fin_d = '0;
        end
        if (state_d == ST_DONE) begin
            fin_d = cnt;
            err_d = (cnt != exp_count(base_q, issued_q));
        end
    end

    // State, command and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            tgt_q        <= '0;
            base_q       <= '0;
            issued_q     <= '0;
            abort_seen_q <= 1'b0;
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            en_q         <= 1'b0;
            rst_n_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            fin_q        <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            base_q       <= base_d;
            issued_q     <= issued_d;
            abort_seen_q <= abort_seen_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            en_q         <= en_d;
            rst_n_q      <= rst_n_d;
            done_q       <= done_d;
            err_q        <= err_d;
            fin_q        <= fin_d;
        end
    end

    assign o_cmd_ready   = ready_q;
    assign o_busy        = busy_q;
    assign o_cnt_enable  = en_q;
    assign o_cnt_rst_n   = rst_n_q;
    assign o_done        = done_q;
    assign o_err         = err_q;
    assign o_final_count = fin_q;

endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: randomized bench with a counter stub and a
// transaction-level model of each command's outcome.
module tb_count_sequencer;

    localparam int SL  = 2;
    localparam int CLR = 3;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [5:0] i_cmd_target;
    logic       i_cmd_clear;
    logic       i_abort;
    logic       o_cnt_enable;
    logic       o_cnt_rst_n;
    logic [2:0] i_count_low;
    logic [2:0] i_count_high;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [5:0] o_final_count;

    logic          inj = 1'b0;
    logic [5:0]    scnt = '0;
    logic [SL-1:0] pipe = '0;

    int n_checks = 0;
    int n_errs   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    count_sequencer #(
        .SYNC_LAT (SL),
        .CLR_LEN  (CLR)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_target  (i_cmd_target),
        .i_cmd_clear   (i_cmd_clear),
        .i_abort       (i_abort),
        .o_cnt_enable  (o_cnt_enable),
        .o_cnt_rst_n   (o_cnt_rst_n),
        .i_count_low   (i_count_low),
        .i_count_high  (i_count_high),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_err         (o_err),
        .o_final_count (o_final_count)
    );

    // Counter stub: enable passes a SL-deep synchronizer, inj adds a stray count.
    always @(posedge clk) begin
        if (!o_cnt_rst_n) begin
            scnt <= '0;
            pipe <= '0;
        end else begin
            pipe <= {pipe[SL-2:0], o_cnt_enable};
            scnt <= scnt + 6'(pipe[SL-1]) + 6'(inj);
        end
    end

    assign i_count_low  = scnt[2:0];
    assign i_count_high = scnt[5:3];

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command from a negedge and follow it to o_done.
    // ab_at: abort on the n-th enable cycle (-1 none); ab_clr: abort in CLEAR.
    task automatic run_cmd(input int tgt, input bit clr, input int ab_at,
                           input bit ab_clr, input bit do_inj);
        int  cyc, en_n, rl_n, iss, base, exp_cnt, exp_lat;
        bit  seen, ab_done, did_inj;
        cyc = 0;
        while (!o_cmd_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ready_wait", int'(o_cmd_ready), 1);
        base = clr ? 0 : model_cnt;
        i_cmd_valid  = 1'b1;
        i_cmd_target = 6'(tgt);
        i_cmd_clear  = clr;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        cyc = 1; en_n = 0; rl_n = 0;
        seen = 0; ab_done = 0; did_inj = 0;
        while (!seen && cyc < 400) begin
            if (o_done) begin
                seen = 1;
            end else begin
                if (o_cnt_enable) en_n++;
                if (!o_cnt_rst_n) rl_n++;
                i_abort = 1'b0;
                inj     = 1'b0;
                if (ab_clr && !o_cnt_rst_n && !ab_done) begin
                    i_abort = 1'b1;
                    ab_done = 1;
                end
                if (o_cnt_enable && en_n == ab_at) i_abort = 1'b1;
                if (do_inj && o_cnt_enable && en_n == 1) begin
                    inj = 1'b1;
                    did_inj = 1;
                end
                @(negedge clk);
                cyc++;
            end
        end
        i_abort = 1'b0;
        inj     = 1'b0;
        if (ab_clr) iss = 0;
        else if (ab_at > 0 && ab_at < tgt) iss = ab_at;
        else iss = tgt;
        exp_cnt = (base + iss + (did_inj ? 1 : 0)) % 64;
        exp_lat = (clr ? CLR + SL + 1 : 0) + iss + SL + 1;
        chk("done_seen", int'(seen), 1);
        chk("en_cycles", en_n, iss);
        chk("rst_low", rl_n, clr ? CLR : 0);
        chk("latency", cyc - 1, exp_lat);
        chk("final", int'(o_final_count), exp_cnt);
        chk("err", int'(o_err), did_inj ? 1 : 0);
        chk("busy_done", int'(o_busy), 1);
        chk("ready_done", int'(o_cmd_ready), 0);
        @(negedge clk);
        chk("done_pulse", int'(o_done), 0);
        chk("ready_after", int'(o_cmd_ready), 1);
        chk("final_hold", int'(o_final_count), exp_cnt);
        model_cnt = exp_cnt;
    endtask

    initial begin
        int n, k, tgt, ab;
        bit clr, abc, dinj;
        i_rst = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_target = '0;
        i_cmd_clear = 1'b0;
        i_abort = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", int'(o_cmd_ready), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_en", int'(o_cnt_enable), 0);
        chk("rst_rstn", int'(o_cnt_rst_n), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_err", int'(o_err), 0);
        chk("rst_final", int'(o_final_count), 0);
        i_rst = 1'b0;
        @(negedge clk);
        chk("post_ready", int'(o_cmd_ready), 1);
        chk("post_rstn", int'(o_cnt_rst_n), 1);
        model_cnt = 0;

        // Directed cases.
        run_cmd(13, 1, -1, 0, 0);
        run_cmd(60, 1, -1, 0, 0);
        run_cmd(10, 0, -1, 0, 0);
        run_cmd(0, 1, -1, 0, 0);
        run_cmd(20, 1, 5, 0, 0);
        run_cmd(8, 1, -1, 0, 1);
        run_cmd(0, 0, -1, 0, 0);
        run_cmd(6, 1, -1, 1, 0);

        // Random commands.
        for (int r = 0; r < 14; r++) begin
            tgt  = int'($urandom_range(0, 63));
            clr  = 1'($urandom_range(0, 1));
            abc  = clr && ($urandom_range(0, 7) == 0);
            ab   = -1;
            if (!abc && tgt > 0 && $urandom_range(0, 3) == 0)
                ab = int'($urandom_range(1, tgt));
            dinj = ($urandom_range(0, 3) == 0);
            run_cmd(tgt, clr, ab, abc, dinj);
        end

        // Reset during RUN with another command held valid.
        i_cmd_valid  = 1'b1;
        i_cmd_target = 6'd20;
        i_cmd_clear  = 1'b1;
        @(negedge clk);
        i_cmd_valid = 1'b0;
        n = 0;
        k = 0;
        while (n < 3 && k < 60) begin
            if (o_cnt_enable) n++;
            if (n < 3) @(negedge clk);
            k++;
        end
        chk("mid_run_en", n, 3);
        i_cmd_valid  = 1'b1;
        i_cmd_target = 6'd4;
        i_cmd_clear  = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("held_ready", int'(o_cmd_ready), 0);
            chk("held_busy", int'(o_busy), 1);
        end
        i_rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_en", int'(o_cnt_enable), 0);
        chk("mid_rst_ready", int'(o_cmd_ready), 0);
        chk("mid_rst_done", int'(o_done), 0);
        i_rst = 1'b0;
        @(negedge clk);
        chk("after_rst_ready", int'(o_cmd_ready), 1);
        chk("after_rst_en", int'(o_cnt_enable), 0);
        model_cnt = 0;
        run_cmd(4, 0, -1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Command-driven controller for the two-digit octal counter (`top`). It accepts run requests over a valid/ready handshake and can clear the counter through its active-low reset. It then gates the counter's enable for an exact number of cycles and checks the resulting count. It sits between the system/testbench command source and the counter, and is the only block allowed to drive the counter's `i_enable` and `i_rst_n`.

## Interface
- `SYNC_LAT`, default 2: counter's internal enable/reset synchronizer depth in cycles.
- `CLR_LEN`, default 3: number of cycles `o_cnt_rst_n` is held low during a clear.
- `i_clk`  in  1  system clock. One clock domain only.
- `i_rst`  in  1  reset, synchronous, active-high.
- `i_cmd_valid`  in  1  command request.
- `o_cmd_ready`  out  1  command accept. High only in IDLE.
- `i_cmd_target`  in  6  number of increments to issue, 0..63.
- `i_cmd_clear`  in  1  1 = clear the counter before the run; 0 = continue from the current count.
- `i_abort`  in  1  stop the current run early.
- `o_cnt_enable`  out  1  drives the counter's `i_enable`.
- `o_cnt_rst_n`  out  1  drives the counter's `i_rst_n`.
- `i_count_low`  in  3  counter's `count_low` (octal units digit).
- `i_count_high`  in  3  counter's `count_high` (octal eights digit).
- `o_busy`  out  1  high in any state other than IDLE.
- `o_done`  out  1  one-cycle completion pulse.
- `o_err`  out  1  count mismatch flag. Valid from `o_done` until the next command accept.
- `o_final_count`  out  6  count sampled at `o_done` as {high, low}. Held until the next accept.

## Operation
- Observed count is cnt = {i_count_high, i_count_low}, a 6-bit value in the range 0..63.
- A command is accepted when `i_cmd_valid && o_cmd_ready`. The accept cycle latches the target, the clear flag, and base:
  - base = 0 when `i_cmd_clear` = 1.
  - base = cnt when `i_cmd_clear` = 0.
- FSM states are IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE → CLEAR on accept with clear = 1.
- IDLE → RUN on accept with clear = 0 and target ≠ 0.
- IDLE → DRAIN on accept with clear = 0 and target = 0.
- CLEAR lasts CLR_LEN + SYNC_LAT + 1 cycles:
  - `o_cnt_rst_n` = 0 for the first CLR_LEN cycles, then 1.
  - Exits to RUN if target ≠ 0, otherwise to DRAIN.
- RUN: `o_cnt_enable` = 1 for exactly `target` consecutive cycles, then DRAIN. An internal `issued` counter tracks these cycles.
- DRAIN lasts SYNC_LAT + 1 cycles with `o_cnt_enable` = 0, then DONE.
- DONE lasts one cycle, then IDLE. In DONE:
  - `o_done` = 1.
  - `o_final_count` = cnt.
  - `o_err` = (cnt ≠ expected), where expected = (base + issued) mod 64.
- Expected-count arithmetic is 6-bit modulo. Wrap from 63 to 0 is legal and not an error.
- Abort handling:
  - `i_abort` in RUN: enable drops the next cycle, go to DRAIN, and expected uses the actual `issued`.
  - `i_abort` in CLEAR: finish the CLEAR state, then go to DRAIN with issued = 0.
  - `i_abort` in IDLE, DRAIN or DONE is ignored.
- While busy, `i_cmd_valid` is not accepted. The requester must hold the command until ready.

## Timing
- Reset values:
  - `o_cmd_ready` = 0, `o_busy` = 0, `o_cnt_enable` = 0, `o_cnt_rst_n` = 0.
  - `o_done` = 0, `o_err` = 0, `o_final_count` = 0.
- First cycle after `i_rst` deasserts: state is IDLE, `o_cmd_ready` = 1, `o_cnt_rst_n` = 1.
- All outputs are registered. The state entered on the cycle after accept drives its outputs on that same cycle.
- Total latency from accept to `o_done`:
  - Clear = 1: CLR_LEN + SYNC_LAT + 1 + target + SYNC_LAT + 1 cycles after the accept cycle.
  - Clear = 0: target + SYNC_LAT + 1 cycles after the accept cycle.
- `o_cmd_ready` rises on the cycle after DONE. A new accept is possible on that cycle, so there are no back-to-back accepts closer than a full sequence.
- `i_rst` in any state: next cycle the block is in IDLE with reset output values. An in-flight command is discarded and no `o_done` is produced.

## Structure
- Package `count_seq_pkg` contains:
  - state enum `seq_state_e`.
  - `CNT_W` = 6 and `DIGIT_W` = 3.
  - function `exp_count(base, issued)` returning the 6-bit modulo sum.
- One sub-module, `seq_timer`: a loadable down-counter with a `zero` flag. It is shared by the CLEAR, RUN and DRAIN durations.
- Top level contains the FSM, the base/issued registers, and the compare logic.

## Test plan
- Reset, then command target = 13 with clear = 1:
  - `o_cnt_rst_n` low for 3 cycles.
  - Enable high for exactly 13 cycles.
  - `o_done` with high = 1, low = 5, `o_err` = 0.
- From count 60 (high 7, low 4), command target = 10 with clear = 0:
  - Count wraps.
  - `o_final_count` = 6, `o_err` = 0.
- Target = 0 with clear = 1:
  - Enable never rises.
  - `o_done` with count 0, `o_err` = 0.
- Target = 20, `i_abort` after 5 enable cycles:
  - Enable drops the next cycle.
  - `o_done` with `o_final_count` = 5, `o_err` = 0.
- Counter stub injects one extra increment during a target = 8 run:
  - `o_final_count` = 9, `o_err` = 1.
- `i_rst` mid-RUN, with a command held valid while busy:
  - Held command is not accepted while busy.
  - After reset, enable is 0 and ready is 1 the next cycle.
  - The held command is accepted once ready is high.
